peri_apb_arb: RTL

//  Two-master arbiter that shares the single peripheral APB bus (uart/spi decode

---
 rtl/peri_apb_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/peri_apb_arb.sv
// peri_apb_arb: round-robin arbiter sharing one downstream APB bus between
// the CPU data port (s0) and the debug module (s1). Each grant carries one
// complete APB transfer. A hung slave is aborted after TIMEOUT ACCESS cycles.
module peri_apb_arb #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s0_psel,
   input  logic                s0_penable,
   input  logic                s0_pwrite,
   input  logic [ADDR_W-1:0]   s0_paddr,
   input  logic [DATA_W-1:0]   s0_pwdata,
   input  logic [DATA_W/8-1:0] s0_pstrb,
   input  logic [2:0]          s0_pprot,
   output logic [DATA_W-1:0]   s0_prdata,
   output logic                s0_pready,
   output logic                s0_pslverr,
   input  logic                s1_psel,
   input  logic                s1_penable,
   input  logic                s1_pwrite,
   input  logic [ADDR_W-1:0]   s1_paddr,
   input  logic [DATA_W-1:0]   s1_pwdata,
   input  logic [DATA_W/8-1:0] s1_pstrb,
   input  logic [2:0]          s1_pprot,
   output logic [DATA_W-1:0]   s1_prdata,
   output logic                s1_pready,
   output logic                s1_pslverr,
   output logic                m_psel,
   output logic                m_penable,
   output logic                m_pwrite,
   output logic [ADDR_W-1:0]   m_paddr,
   output logic [DATA_W-1:0]   m_pwdata,
   output logic [DATA_W/8-1:0] m_pstrb,
   output logic [2:0]          m_pprot,
   input  logic [DATA_W-1:0]   m_prdata,
   input  logic                m_pready,
   input  logic                m_pslverr
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic                gnt_q, gnt_d;
   logic                last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic [2:0]          prot_q, prot_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                gsel;

   // A request is psel alone; penable carries no extra information here.
   logic unused_penable;
   assign unused_penable = ^{s0_penable, s1_penable};

   // State and captured-transfer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         prot_q  <= prot_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Arbitration, transfer sequencing and timeout abort.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      prot_d  = prot_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      gsel    = (s0_psel && s1_psel) ? ~last_q : s1_psel;
      case (state_q)
         IDLE: begin
            if (s0_psel || s1_psel) begin
               gnt_d   = gsel;
               last_d  = gsel;
               write_d = gsel ? s1_pwrite : s0_pwrite;
               addr_d  = gsel ? s1_paddr  : s0_paddr;
               wdata_d = gsel ? s1_pwdata : s0_pwdata;
               strb_d  = gsel ? s1_pstrb  : s0_pstrb;
               prot_d  = gsel ? s1_pprot  : s0_pprot;
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (m_pready) begin
               rdata_d = m_prdata;
               err_d   = m_pslverr;
               state_d = DONE;
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode from registered state; forced to zero while rst is high.
   always_comb begin
      m_psel     = !rst && (state_q == SETUP || state_q == ACCESS);
      m_penable  = !rst && (state_q == ACCESS);
      m_pwrite   = !rst && write_q;
      m_paddr    = rst ? '0 : addr_q;
      m_pwdata   = rst ? '0 : wdata_q;
      m_pstrb    = rst ? '0 : strb_q;
      m_pprot    = rst ? '0 : prot_q;
      s0_pready  = !rst && (state_q == DONE) && !gnt_q;
      s1_pready  = !rst && (state_q == DONE) &&  gnt_q;
      s0_pslverr = s0_pready && err_q;
      s1_pslverr = s1_pready && err_q;
      s0_prdata  = rst ? '0 : rdata_q;
      s1_prdata  = rst ? '0 : rdata_q;
   end

endmodule
